// File: rtl/md_sequencer.sv
// md_sequencer
//   Multiply/divide controller for the E stage. A one-cycle Start with MDOp
//   1..4 computes the result up front into a pending HI/LO pair, then holds
//   Busy for a fixed latency before committing it to the architectural HI/LO.
//   A new Start while Busy aborts the in-flight operation and restarts the
//   latency, so the youngest writer wins. mthi/mtlo write A directly when idle.
//
// Parameters
//   MULT_CYCLES  Busy cycles for mult/multu (1..15)
//   DIV_CYCLES   Busy cycles for div/divu   (1..15)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, clears all state
//   Start  in   E-stage instruction is mult/multu/div/divu
//   MDOp   in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 no-op
//   A, B   in   forwarded rs / rt operands
//   MFSel  in   read select for MDOut: 0 LO, 1 HI
//   Busy   out  operation in flight (registered)
//   HI, LO out  architectural HI / LO registers
//   MDOut  out  MFSel ? HI : LO, no bypass of the pending result
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MFSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int DATA_W = 32;
  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] pHI;
  logic [DATA_W-1:0] pLO;
  logic              pV;

  // Each function returns {HI, LO}.
  function automatic logic [2*DATA_W-1:0] mul_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] ae;
    logic signed [2*DATA_W-1:0] be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic [2*DATA_W-1:0] mul_unsigned(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [2*DATA_W-1:0] ae;
    logic [2*DATA_W-1:0] be;
    ae = {{DATA_W{1'b0}}, a};
    be = {{DATA_W{1'b0}}, b};
    return ae * be;
  endfunction

  // Truncating signed divide; remainder follows the dividend's sign. The
  // single overflowing case saturates to the most-negative quotient.
  function automatic logic [2*DATA_W-1:0] div_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      q = 32'sh8000_0000;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [2*DATA_W-1:0] div_unsigned(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic                md_start;
  logic                md_is_mult;
  logic [2*DATA_W-1:0] res;
  logic                res_v;

  assign md_start   = Start && (MDOp >= 3'd1) && (MDOp <= 3'd4);
  assign md_is_mult = (MDOp == 3'd1) || (MDOp == 3'd2);

  always_comb begin
    res   = '0;
    res_v = 1'b0;
    case (MDOp)
      3'd1: begin res = mul_signed($signed(A), $signed(B)); res_v = 1'b1;      end
      3'd2: begin res = mul_unsigned(A, B);                 res_v = 1'b1;      end
      3'd3: begin res = div_signed($signed(A), $signed(B)); res_v = (B != '0); end
      3'd4: begin res = div_unsigned(A, B);                 res_v = (B != '0); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      pHI   <= '0;
      pLO   <= '0;
      pV    <= 1'b0;
    end else if (md_start) begin
      // A start overrides whatever is in flight, including its final cycle.
      state <= md_is_mult ? S_MULT : S_DIV;
      cnt   <= md_is_mult ? MULT_CNT : DIV_CNT;
      Busy  <= (md_is_mult ? MULT_CNT : DIV_CNT) != '0;
      pHI   <= res[2*DATA_W-1:DATA_W];
      pLO   <= res[DATA_W-1:0];
      pV    <= res_v;
    end else begin
      case (state)
        S_IDLE: begin
          if (!Start && !Busy) begin
            if (MDOp == 3'd5) HI <= A;
            if (MDOp == 3'd6) LO <= A;
          end
        end
        S_MULT, S_DIV: begin
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            Busy  <= 1'b0;
            state <= S_IDLE;
            if (pV) begin
              HI <= pHI;
              LO <= pLO;
            end
          end else begin
            cnt  <= cnt - 4'd1;
            Busy <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign MDOut = MFSel ? HI : LO;

endmodule
